// File: rtl/toggle_monitor.sv
// Toggle monitor: measures half-period of a synchronous toggling input,
// flags early/late intervals and missing edges, and reports lock.
module toggle_monitor #(
  parameter int CNT_W   = 8,
  parameter int EXPECT  = 1,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 16,
  parameter int LOCK_N  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic             clr,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             err_early,
  output logic             err_late,
  output logic             timeout,
  output logic             locked,
  output logic [15:0]      edge_count
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;

  localparam int LO_I  = (EXPECT - TOL < 1) ? 1 : EXPECT - TOL;
  localparam int HI_I  = EXPECT + TOL;
  localparam int RUN_W = $clog2(LOCK_N + 1);

  localparam logic [31:0]      LO      = 32'(LO_I);
  localparam logic [31:0]      HI      = 32'(HI_I);
  localparam logic [31:0]      TO_LIM  = 32'(TIMEOUT);
  localparam logic [31:0]      LOCK_LIM = 32'(LOCK_N);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);

  state_t           state_q, state_d;
  logic             din_q;
  logic [CNT_W-1:0] cnt;
  logic [RUN_W-1:0] run;

  logic        edge_det;
  logic [31:0] cnt_ext;
  logic        meas_edge;
  logic        to_fire;
  logic        early;
  logic        late;

  always_comb begin
    edge_det  = din ^ din_q;
    cnt_ext   = 32'(cnt);
    meas_edge = (state_q == MEASURE) && enable && edge_det;
    to_fire   = (state_q == MEASURE) && enable && !edge_det && (cnt_ext >= TO_LIM);
    early     = meas_edge && (cnt_ext < LO);
    late      = meas_edge && (cnt_ext > HI);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = ACQUIRE;
      ACQUIRE: if (edge_det) state_d = MEASURE;
      MEASURE: if (to_fire) state_d = ACQUIRE;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      din_q        <= 1'b0;
      cnt          <= '0;
      run          <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      err_early    <= 1'b0;
      err_late     <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
      edge_count   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din;

      if (edge_det)
        cnt <= CNT_W'(1);
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);

      period_valid <= meas_edge;
      if (meas_edge) begin
        half_period <= cnt;
        edge_count  <= edge_count + 16'd1;
      end

      // A new event in the same cycle takes precedence over clr.
      err_early <= early   | (err_early & ~clr);
      err_late  <= late    | (err_late  & ~clr);
      timeout   <= to_fire | (timeout   & ~clr);

      if (!enable || to_fire) begin
        run    <= '0;
        locked <= 1'b0;
      end else if (meas_edge) begin
        if (early || late) begin
          run    <= '0;
          locked <= 1'b0;
        end else begin
          if (run < RUN_MAX) run <= run + RUN_W'(1);
          if (32'(run) + 32'd1 >= LOCK_LIM) locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboarded bench for toggle_monitor: measured edges push expected
// (half_period, edge_count); a negedge monitor pops on each period_valid.
module tb_toggle_monitor;

  logic clk = 1'b0;
  logic rst, en, din, clr;
  logic en3, din3, clr3;

  logic [7:0]  hp, hp3;
  logic        pv, ee, el, to, lk;
  logic        pv3, ee3, el3, to3, lk3;
  logic [15:0] ec, ec3;

  typedef struct packed {
    logic [7:0]  hp;
    logic [15:0] ec;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          pend     = 0;
  logic [15:0] exp_ec   = '0;

  always #5 clk = ~clk;

  toggle_monitor u_def (
    .clk(clk), .rst(rst), .enable(en), .din(din), .clr(clr),
    .half_period(hp), .period_valid(pv), .err_early(ee), .err_late(el),
    .timeout(to), .locked(lk), .edge_count(ec)
  );

  toggle_monitor #(.EXPECT(3), .TOL(0)) u_e3 (
    .clk(clk), .rst(rst), .enable(en3), .din(din3), .clr(clr3),
    .half_period(hp3), .period_valid(pv3), .err_early(ee3), .err_late(el3),
    .timeout(to3), .locked(lk3), .edge_count(ec3)
  );

  always @(negedge clk) begin
    if (pv) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL pv_unexpected: got hp=%0d ec=%0d, required no pulse", hp, ec);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (hp !== e.hp || ec !== e.ec) begin
          failures++;
          $display("FAIL pv_data: got hp=%0d ec=%0d, required hp=%0d ec=%0d",
                   hp, ec, e.hp, e.ec);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pend++;
  endtask

  task automatic flip(input int sel);
    if (sel == 0) din = ~din;
    else din3 = ~din3;
    pend = 0;
  endtask

  task automatic gap(input int sel, input int n, input bit meas);
    while (pend < n) tick();
    if (meas && sel == 0) begin
      exp_ec++;
      q.push_back('{hp: 8'(n), ec: exp_ec});
    end
    flip(sel);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hp"}, 32'(hp), 0);
    chk({tag, "_flags"}, {27'd0, pv, ee, el, to, lk}, 0);
    chk({tag, "_ec"}, 32'(ec), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = 1'b0; clr = 1'b0;
    en3 = 1'b0; din3 = 1'b0; clr3 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");

    // Toggle every cycle: lock after the 4th measured edge.
    tick();
    flip(0);
    gap(0, 1, 1); gap(0, 1, 1); gap(0, 1, 1);
    tick();
    chk("lock_after3", 32'(lk), 0);
    gap(0, 1, 1);
    tick();
    chk("lock_after4", 32'(lk), 1);
    for (int i = 0; i < 6; i++) gap(0, 1, 1);
    tick();
    chk("t1_hp", 32'(hp), 1);
    chk("t1_errs", {29'd0, ee, el, to}, 0);
    chk("t1_ec", 32'(ec), 10);

    // Hold din: timeout after the 16th stalled count.
    while (pend < 16) tick();
    chk("to_before", {30'd0, to, lk}, 32'b01);
    tick();
    chk("to_fire", {30'd0, to, lk}, 32'b10);
    flip(0);
    tick();
    chk("acq_edge_ec", 32'(ec), 32'(exp_ec));
    chk("acq_edge_pv", 32'(pv), 0);
    gap(0, 1, 1);

    // Late interval coinciding with clr: the new flag wins.
    gap(0, 2, 1);
    clr = 1'b1;
    tick();
    chk("clr_vs_late", {29'd0, ee, el, to}, 32'b010);
    chk("late_unlock", 32'(lk), 0);
    gap(0, 1, 1);
    tick();
    chk("clr_alone", 32'(el), 0);
    clr = 1'b0;
    gap(0, 1, 1); gap(0, 1, 1); gap(0, 1, 1);
    tick();
    chk("relock", 32'(lk), 1);

    // Disable while locked, then re-enable.
    en = 1'b0;
    tick();
    chk("dis_lock", 32'(lk), 0);
    chk("dis_hp_held", 32'(hp), 1);
    chk("dis_ec_held", 32'(ec), 32'(exp_ec));
    flip(0); tick(); flip(0); tick();
    en = 1'b1;
    tick();
    flip(0);
    tick();
    chk("reen_first_pv", 32'(pv), 0);
    chk("reen_first_ec", 32'(ec), 32'(exp_ec));
    gap(0, 1, 1);
    tick();
    chk("reen_meas_ec", 32'(ec), 32'(exp_ec));

    // EXPECT=3 instance: lock, early interval, relock.
    en3 = 1'b1;
    tick();
    flip(1);
    for (int i = 0; i < 4; i++) gap(1, 3, 0);
    tick();
    chk("e3_lock", {29'd0, lk3, ee3, el3}, 32'b100);
    chk("e3_hp", 32'(hp3), 3);
    gap(1, 2, 0);
    tick();
    chk("e3_early", {30'd0, ee3, lk3}, 32'b10);
    chk("e3_hp_early", 32'(hp3), 2);
    for (int i = 0; i < 3; i++) gap(1, 3, 0);
    tick();
    chk("e3_relock3", 32'(lk3), 0);
    gap(1, 3, 0);
    tick();
    chk("e3_relock4", {29'd0, lk3, ee3, el3}, 32'b110);
    en3 = 1'b0;

    // edge_count wrap, then reset in the middle of MEASURE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ec = '0;
    chk_zero("rst2");
    tick();
    flip(0);
    for (int i = 0; i < 65535; i++) gap(0, 1, 1);
    tick();
    chk("ec_max", 32'(ec), 32'h0000FFFF);
    gap(0, 1, 1);
    tick();
    chk("ec_wrap", 32'(ec), 0);
    gap(0, 1, 1);
    tick();
    chk("pre_rst_lk", 32'(lk), 1);
    rst = 1'b1;
    flip(0);
    tick();
    rst = 1'b0;
    exp_ec = '0;
    chk_zero("rst_mid");
    tick();
    flip(0);
    gap(0, 3, 1);
    tick();
    chk("post_rst_ec", 32'(ec), 1);
    chk("post_rst_late", 32'(el), 1);
    tick();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_monitor.md
TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, interval counter and result width.
REQ-002 SHALL have parameter EXPECT, default 1, nominal half-period in clock cycles.
REQ-003 SHALL have parameter TOL, default 0, allowed deviation from EXPECT in cycles.
REQ-004 SHALL have parameter TIMEOUT, default 16, cycles without an edge before the timeout fires.
REQ-005 SHALL have parameter LOCK_N, default 4, consecutive in-tolerance intervals required for lock.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port enable, input, 1 bit: monitoring enable.
REQ-010 SHALL have port din, input, 1 bit: monitored toggling signal, already synchronous to clk.
REQ-011 SHALL have port clr, input, 1 bit: clears the sticky error flags.
REQ-012 SHALL have port half_period, output, CNT_W bits: last measured interval length.
REQ-013 SHALL have port period_valid, output, 1 bit: one-cycle pulse when half_period updates.
REQ-014 SHALL have ports err_early and err_late, output, 1 bit each: sticky, interval shorter or longer than tolerance.
REQ-015 SHALL have port timeout, output, 1 bit: sticky, no edge within TIMEOUT cycles.
REQ-016 SHALL have port locked, output, 1 bit: stable toggling confirmed.
REQ-017 SHALL have port edge_count, output, 16 bits: edges seen in MEASURE; wraps 0xFFFF to 0.

Function
REQ-018 SHALL register din into din_q each cycle and detect an edge when din differs from din_q.
REQ-019 SHALL implement states IDLE, ACQUIRE and MEASURE.
REQ-020 SHALL move IDLE to ACQUIRE when enable=1.
REQ-021 SHALL move ACQUIRE to MEASURE on the first edge; that edge is not measured or counted.
REQ-022 SHALL return to IDLE from any state when enable=0, clear locked and hold all other outputs.
REQ-023 SHALL set interval counter cnt to 1 on an edge, otherwise increment it, saturating at 2^CNT_W-1.
REQ-024 SHALL, on an edge in MEASURE, load half_period with cnt, pulse period_valid for one cycle and increment edge_count; a signal toggling every cycle gives half_period=1.
REQ-025 SHALL register all outputs one cycle after the detecting edge.
REQ-026 SHALL set err_early on a measured cnt below EXPECT-TOL and err_late on a measured cnt above EXPECT+TOL; the lower bound clamps at 1.
REQ-027 SHALL count consecutive in-tolerance intervals in a run counter, assert locked when the run reaches LOCK_N, and clear the run and locked on any out-of-tolerance interval.
REQ-028 SHALL, in MEASURE, when cnt reaches TIMEOUT with no edge, set timeout, clear locked and the run counter, and go to ACQUIRE.
REQ-029 SHALL clear err_early, err_late and timeout with clr=1, and a flag set in the same cycle SHALL win over clr.
REQ-030 SHALL leave locked, half_period and edge_count unaffected by clr.

Reset
REQ-031 SHALL, with rst=1 at a rising edge, enter IDLE and clear half_period, period_valid, err_early, err_late, timeout, locked, edge_count, cnt, din_q and the run counter.
REQ-032 SHALL give rst priority over enable and clr, and SHALL discard any measurement in progress when reset is applied mid-operation.

Verification
REQ-033 Bench SHALL cover: defaults, enable=1, din toggles every cycle for 10 cycles -> half_period=1, period_valid on each edge, locked after the 4th measured edge, no errors.
REQ-034 Bench SHALL cover: EXPECT=3, TOL=0, din locked at 3-cycle half-period then one 2-cycle interval -> err_early=1, locked=0, relocks after 4 further good intervals, err_early stays 1.
REQ-035 Bench SHALL cover: din held constant 16 cycles in MEASURE with defaults -> timeout=1, locked=0, state ACQUIRE; next edge is not counted.
REQ-036 Bench SHALL cover: clr=1 in the same cycle as a new err_late event -> err_late remains 1; clr alone the next cycle -> 0.
REQ-037 Bench SHALL cover: edge_count at 0xFFFF plus one edge -> 0x0000; rst mid-MEASURE -> all outputs 0 the next cycle.
REQ-038 Bench SHALL cover: enable dropped while locked -> locked=0 and half_period held; re-enable -> first edge unmeasured.
